// File: rtl/spi_tap_capture.sv
// spi_tap_capture: taps one selected SPI interface out of a quadrant/interface
// grid, timestamps the line states and stores them in an on-chip capture RAM.
// Three capture modes are supported:
//   continuous  - every sample is stored until the RAM is full
//   change-only - a sample is stored only when the line state differs from the
//                 last stored one
//   triggered   - samples are stored circularly until a chip-select falling
//                 transition, then a programmable number of post-trigger
//                 samples is stored
// Readback is a fire-and-forget request: i_rd_req/i_rd_addr is taken in any
// cycle where o_busy is low (there is no ready/backpressure), and exactly two
// cycles later o_rd_valid pulses for one cycle with the word in o_rd_data.
// Requests made while o_busy is high are dropped and never answered.
module spi_tap_capture #(
  parameter int P_NUM_QUADRANTS = 4,
  parameter int P_NUM_SPI_IF    = 8,
  parameter int P_ADDR_WD       = 10,
  parameter int P_TS_WD         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic                               i_abort,
  input  logic [1:0]                         i_mode,
  input  logic [$clog2(P_NUM_QUADRANTS)-1:0] i_sel_quadrant,
  input  logic [$clog2(P_NUM_SPI_IF)-1:0]    i_sel_if,
  input  logic [P_ADDR_WD-1:0]               i_post_count,
  input  logic                               i_spi_sdo [P_NUM_QUADRANTS][P_NUM_SPI_IF],
  input  logic                               i_spi_pdi [P_NUM_QUADRANTS][P_NUM_SPI_IF],
  input  logic                               i_spi_sdi [P_NUM_QUADRANTS][P_NUM_SPI_IF],
  input  logic [1:0]                         i_spi_csb [P_NUM_QUADRANTS][P_NUM_SPI_IF],
  input  logic                               i_rd_req,
  input  logic [P_ADDR_WD-1:0]               i_rd_addr,
  output logic [P_TS_WD+4:0]                 o_rd_data,
  output logic                               o_rd_valid,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [P_ADDR_WD:0]                 o_wr_count,
  output logic [P_ADDR_WD-1:0]               o_trig_addr,
  output logic [1:0]                         o_dbg_state
);

  localparam int QW = $clog2(P_NUM_QUADRANTS);
  localparam int IW = $clog2(P_NUM_SPI_IF);
  localparam int SW = P_TS_WD + 5;
  localparam int NWORDS = 1 << P_ADDR_WD;

  // Number of words in the RAM, and the write count at which the last
  // free word is being written.
  localparam logic [P_ADDR_WD:0] DEPTH = {1'b1, {P_ADDR_WD{1'b0}}};
  localparam logic [P_ADDR_WD:0] LAST  = DEPTH - 1'b1;

  localparam logic [1:0] M_CONT = 2'd0;
  localparam logic [1:0] M_CHG  = 2'd1;
  localparam logic [1:0] M_TRIG = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration latched on an accepted start
  logic [1:0]           mode_q;
  logic [QW-1:0]        sel_quad_q;
  logic [IW-1:0]        sel_if_q;
  logic [P_ADDR_WD-1:0] post_q;

  // Sample stage: selected lines plus the timestamp they were taken at
  logic [P_TS_WD-1:0]   ts;
  logic                 samp_vld;
  logic [4:0]           samp_vec;
  logic [P_TS_WD-1:0]   samp_ts;
  logic [4:0]           sel_vec;

  // Capture bookkeeping
  logic [P_ADDR_WD-1:0] wr_ptr;
  logic [P_ADDR_WD:0]   wr_count;
  logic [P_ADDR_WD-1:0] post_cnt;
  logic [4:0]           last_vec;
  logic                 first_wr;
  logic [P_ADDR_WD-1:0] trig_addr;

  // Control decodes
  logic                 start_acc;
  logic                 active;
  logic                 wr_en;
  logic                 trig_hit;
  logic                 full_hit;
  logic                 post_hit;

  // Capture RAM and readback pipeline
  logic [SW-1:0]        mem [0:NWORDS-1];
  logic [SW-1:0]        ram_q;
  logic                 rd_acc;
  logic                 rd_p1;

  assign start_acc = i_start && ((state == S_IDLE) || (state == S_DONE));
  assign active    = (state == S_ARM) || (state == S_CAPTURE);
  assign rd_acc    = i_rd_req && !active;

  // Word order {csb, pdi, sdi, sdo}; the timestamp is prepended at write time
  assign sel_vec = {i_spi_csb[sel_quad_q][sel_if_q],
                    i_spi_pdi[sel_quad_q][sel_if_q],
                    i_spi_sdi[sel_quad_q][sel_if_q],
                    i_spi_sdo[sel_quad_q][sel_if_q]};

  assign o_wr_count  = wr_count;
  assign o_trig_addr = trig_addr;
  assign o_dbg_state = state;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state; abort wins over a same-cycle trigger or full condition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (i_abort) begin
          state_nxt = S_IDLE;
        end else if (mode_q != M_TRIG) begin
          state_nxt = S_CAPTURE;
        end else if (trig_hit) begin
          state_nxt = (post_q == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (i_abort) begin
          state_nxt = S_IDLE;
        end else if (full_hit || post_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) state_nxt = S_ARM;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and per-cycle write/trigger decisions
  always_comb begin
    o_busy   = active;
    o_done   = (state == S_DONE);
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    if (active && samp_vld && !i_abort) begin
      case (mode_q)
        M_CHG: begin
          wr_en = (state == S_CAPTURE) && (first_wr || (samp_vec != last_vec));
        end
        M_TRIG: begin
          // In triggered mode every sample is stored, so last_vec is the
          // previous sample and the falling-edge test can use it directly.
          wr_en    = 1'b1;
          trig_hit = (state == S_ARM) && !first_wr &&
                     (last_vec[4:3] == 2'b11) && (samp_vec[4:3] != 2'b11);
        end
        default: begin
          wr_en = (state == S_CAPTURE);
        end
      endcase
    end
    full_hit = wr_en && (mode_q != M_TRIG) && (wr_count == LAST);
    // post_q is P_ADDR_WD bits wide, so the post-trigger run can never
    // exceed one word less than the RAM and cannot overwrite the trigger.
    post_hit = wr_en && (mode_q == M_TRIG) && (state == S_CAPTURE) &&
               (({1'b0, post_cnt} + 1'b1) == {1'b0, post_q});
  end

  // Configuration latch on accepted start; starts while busy are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= M_CONT;
      sel_quad_q <= '0;
      sel_if_q   <= '0;
      post_q     <= '0;
    end else if (start_acc) begin
      mode_q     <= (i_mode == 2'd3) ? M_CONT : i_mode;
      sel_quad_q <= i_sel_quadrant;
      sel_if_q   <= i_sel_if;
      post_q     <= i_post_count;
    end
  end

  // Sample stage and free-running-while-active saturating timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      samp_vld <= 1'b0;
      samp_vec <= '0;
      samp_ts  <= '0;
    end else begin
      samp_vld <= active;
      samp_vec <= sel_vec;
      samp_ts  <= ts;
      if (start_acc) begin
        ts <= '0;
      end else if (active && (ts != {P_TS_WD{1'b1}})) begin
        ts <= ts + 1'b1;
      end
    end
  end

  // Write pointer, stored-sample count, post-trigger count and trigger address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      wr_count  <= '0;
      post_cnt  <= '0;
      last_vec  <= '0;
      first_wr  <= 1'b1;
      trig_addr <= '0;
    end else if (start_acc) begin
      wr_ptr    <= '0;
      wr_count  <= '0;
      post_cnt  <= '0;
      last_vec  <= '0;
      first_wr  <= 1'b1;
      trig_addr <= '0;
    end else if (wr_en) begin
      wr_ptr   <= wr_ptr + 1'b1;
      last_vec <= samp_vec;
      first_wr <= 1'b0;
      if (wr_count != DEPTH) wr_count <= wr_count + 1'b1;
      if (trig_hit) trig_addr <= wr_ptr;
      if ((state == S_CAPTURE) && (mode_q == M_TRIG)) post_cnt <= post_cnt + 1'b1;
    end
  end

  // Capture RAM: one write port, one registered read port, contents not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {samp_ts, samp_vec};
    if (rd_acc) ram_q <= mem[i_rd_addr];
  end

  // Readback pipeline: request -> RAM read -> output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1      <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      rd_p1      <= rd_acc;
      o_rd_valid <= rd_p1;
      if (rd_p1) o_rd_data <= ram_q;
    end
  end

endmodule

// File: tb/tb_spi_tap_capture.sv
// tb_spi_tap_capture: table of capture scenarios with expected busy length,
// done flag, stored count and trigger address; stored contents are predicted
// by a behavioural model and checked through the readback port, followed by
// hand-written readback latency, busy-read and reset sequences.
module tb_spi_tap_capture;

  localparam int NQ    = 4;
  localparam int NI    = 8;
  localparam int AW    = 4;
  localparam int TW    = 16;
  localparam int SW    = TW + 5;
  localparam int DEPTH = 16;
  localparam int NVEC  = 10;

  localparam int PAT_COUNT  = 0;
  localparam int PAT_TOGGLE = 1;
  localparam int PAT_TRIG   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [1:0]    i_mode = '0;
  logic [1:0]    i_sel_quadrant = '0;
  logic [2:0]    i_sel_if = '0;
  logic [AW-1:0] i_post_count = '0;
  logic          spi_sdo [NQ][NI];
  logic          spi_pdi [NQ][NI];
  logic          spi_sdi [NQ][NI];
  logic [1:0]    spi_csb [NQ][NI];
  logic          i_rd_req = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [SW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_wr_count;
  logic [AW-1:0] o_trig_addr;
  logic [1:0]    o_dbg_state;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int model_wr = 0;
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] exp_mem [DEPTH];

  typedef struct {
    logic [1:0] mode;
    int         pat;
    int         sq;
    int         si;
    int         ta;
    int         tb;
    int         trig;
    int         post;
    int         abort_at;
    int         restart_at;
    bit         rd_busy;
    int         exp_busy;
    int         exp_wr;
    int         exp_trig;
    bit         exp_done;
  } vec_t;

  vec_t tbl [NVEC];

  spi_tap_capture #(
    .P_NUM_QUADRANTS(NQ),
    .P_NUM_SPI_IF   (NI),
    .P_ADDR_WD      (AW),
    .P_TS_WD        (TW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_mode        (i_mode),
    .i_sel_quadrant(i_sel_quadrant),
    .i_sel_if      (i_sel_if),
    .i_post_count  (i_post_count),
    .i_spi_sdo     (spi_sdo),
    .i_spi_pdi     (spi_pdi),
    .i_spi_sdi     (spi_sdi),
    .i_spi_csb     (spi_csb),
    .i_rd_req      (i_rd_req),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_wr_count    (o_wr_count),
    .o_trig_addr   (o_trig_addr),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line state {csb, pdi, sdi, sdo} of the observed interface at timestamp k
  function automatic logic [4:0] vec_at(input vec_t v, input int k);
    logic [4:0] r;
    int t;
    t = k;
    case (v.pat)
      PAT_TOGGLE: r = {2'b11, 1'b0, 1'b0, ((k >= v.ta) ^ (k >= v.tb))};
      PAT_TRIG:   r = {((k >= v.trig) ? 2'b00 : 2'b11), t[1], t[2], t[0]};
      default: begin
        t = k * 7 + 3;
        r = t[4:0];
      end
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Observed interface gets the pattern, every other interface its inverse
  task automatic drive_lines(input vec_t v, input int k);
    logic [4:0] c;
    logic [4:0] d;
    c = vec_at(v, k);
    for (int q = 0; q < NQ; q++) begin
      for (int i = 0; i < NI; i++) begin
        d = ((q == v.sq) && (i == v.si)) ? c : ~c;
        spi_csb[q][i] = d[4:3];
        spi_pdi[q][i] = d[2];
        spi_sdi[q][i] = d[1];
        spi_sdo[q][i] = d[0];
      end
    end
  endtask

  task automatic run_capture(input vec_t v, output int busy_n);
    int k;
    i_mode         = v.mode;
    i_sel_quadrant = 2'(v.sq);
    i_sel_if       = 3'(v.si);
    i_post_count   = 4'(v.post);
    drive_lines(v, 0);
    i_start = 1'b1;
    tick();
    i_start  = 1'b0;
    i_rd_req = v.rd_busy;
    i_rd_addr = '0;
    busy_n = 0;
    k = 0;
    while ((k < 300) && o_busy) begin
      busy_n++;
      drive_lines(v, k);
      i_abort = (k == v.abort_at);
      if (k == v.restart_at) begin
        i_start        = 1'b1;
        i_mode         = 2'd2;
        i_sel_quadrant = ~i_sel_quadrant;
        i_sel_if       = ~i_sel_if;
        i_post_count   = 4'd3;
      end
      tick();
      i_abort = 1'b0;
      i_start = 1'b0;
      k++;
    end
    i_rd_req = 1'b0;
    check("capture_timeout", (k >= 300), 0);
  endtask

  task automatic read_burst(input int n);
    for (int a = 0; a < n; a++) begin
      i_rd_req  = 1'b1;
      i_rd_addr = 4'(a);
      exp_q.push_back(exp_mem[a]);
      tick();
    end
    i_rd_req = 1'b0;
    repeat (3) tick();
  endtask

  // Expected RAM contents for a scenario, from the capture rules
  task automatic build_model(input vec_t v);
    int writes;
    int kmax;
    int trig_k;
    bit first;
    bit wr;
    logic [4:0] cur;
    logic [4:0] prev;
    logic [4:0] last;
    writes = 0;
    trig_k = -1;
    first  = 1'b1;
    last   = '0;
    prev   = '0;
    kmax   = (v.abort_at >= 0) ? v.abort_at - 2 : 400;
    for (int k = 0; k <= kmax; k++) begin
      cur = vec_at(v, k);
      if (v.mode == 2'd1) wr = first || (cur != last);
      else                wr = 1'b1;
      if (wr) begin
        if (v.mode == 2'd2) exp_mem[k % DEPTH] = {16'(k), cur};
        else                exp_mem[writes]    = {16'(k), cur};
        writes++;
        last  = cur;
        first = 1'b0;
      end
      if (v.mode == 2'd2) begin
        if ((trig_k < 0) && (k > 0) && (prev[4:3] == 2'b11) && (cur[4:3] != 2'b11)) trig_k = k;
        if ((trig_k >= 0) && (k == trig_k + v.post)) break;
      end else if (writes == DEPTH) begin
        break;
      end
      prev = cur;
    end
    model_wr = (writes > DEPTH) ? DEPTH : writes;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [SW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (o_rd_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected_valid: got valid data %0h expected no valid", o_rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", o_rd_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_n;
    int v0;
    logic [7:0] vpat;
    vec_t va;

    //          mode  pat         sq si ta tb trig post abort rst  rdb  busy wr trig done
    tbl[0] = '{2'd0, PAT_COUNT,  1, 2, 0, 0, 0,   0,   -1,   -1,  1'b0, 17, 16, 0, 1'b1};
    tbl[1] = '{2'd1, PAT_TOGGLE, 2, 5, 3, 7, 0,   0,   12,   -1,  1'b0, 13, 3,  0, 1'b0};
    tbl[2] = '{2'd2, PAT_TRIG,   3, 7, 0, 0, 20,  5,   -1,   -1,  1'b0, 27, 16, 4, 1'b1};
    tbl[3] = '{2'd0, PAT_COUNT,  0, 0, 0, 0, 0,   0,   6,    -1,  1'b0, 7,  5,  0, 1'b0};
    tbl[4] = '{2'd2, PAT_TRIG,   0, 3, 0, 0, 5,   0,   -1,   -1,  1'b0, 7,  6,  5, 1'b1};
    tbl[5] = '{2'd2, PAT_TRIG,   2, 1, 0, 0, 3,   15,  -1,   -1,  1'b0, 20, 16, 3, 1'b1};
    tbl[6] = '{2'd3, PAT_COUNT,  1, 6, 0, 0, 0,   0,   -1,   -1,  1'b0, 17, 16, 0, 1'b1};
    tbl[7] = '{2'd1, PAT_COUNT,  3, 0, 0, 0, 0,   0,   -1,   -1,  1'b0, 17, 16, 0, 1'b1};
    tbl[8] = '{2'd0, PAT_COUNT,  2, 4, 0, 0, 0,   0,   -1,   5,   1'b0, 17, 16, 0, 1'b1};
    tbl[9] = '{2'd2, PAT_TRIG,   1, 1, 0, 0, 8,   2,   -1,   -1,  1'b1, 12, 11, 8, 1'b1};

    drive_lines(tbl[0], 0);

    // Reset values while rst_n is held low
    repeat (2) tick();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_wr_count", o_wr_count, 0);
    check("rst_trig_addr", o_trig_addr, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_state", o_dbg_state, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven capture scenarios
    for (int n = 0; n < NVEC; n++) begin
      v0 = valid_cnt;
      run_capture(tbl[n], busy_n);
      check($sformatf("busy_cycles[%0d]", n), busy_n, tbl[n].exp_busy);
      check($sformatf("done[%0d]", n), o_done, tbl[n].exp_done);
      check($sformatf("state[%0d]", n), o_dbg_state, tbl[n].exp_done ? 2'd3 : 2'd0);
      check($sformatf("wr_count[%0d]", n), o_wr_count, tbl[n].exp_wr);
      if (tbl[n].mode == 2'd2) check($sformatf("trig_addr[%0d]", n), o_trig_addr, tbl[n].exp_trig);
      repeat (3) tick();
      if (tbl[n].rd_busy) check("rd_during_busy", valid_cnt - v0, 0);
      build_model(tbl[n]);
      read_burst(model_wr);
    end

    // Single read: valid exactly two cycles after the request
    i_rd_req  = 1'b1;
    i_rd_addr = 4'd2;
    exp_q.push_back(exp_mem[2]);
    tick();
    i_rd_req = 1'b0;
    check("rd_latency_1", o_rd_valid, 0);
    tick();
    check("rd_latency_2", o_rd_valid, 1);
    tick();
    check("rd_latency_3", o_rd_valid, 0);
    repeat (2) tick();

    // Back-to-back burst of 4: valid on four consecutive cycles
    vpat = '0;
    for (int c = 0; c < 8; c++) begin
      vpat[c] = o_rd_valid;
      if (c < 4) begin
        i_rd_req  = 1'b1;
        i_rd_addr = 4'(c);
        exp_q.push_back(exp_mem[c]);
      end else begin
        i_rd_req = 1'b0;
      end
      tick();
    end
    check("rd_burst_pattern", vpat, 8'b0011_1100);
    repeat (2) tick();

    // Reset while a read is in flight in DONE: everything clears, no valid
    v0 = valid_cnt;
    i_rd_req  = 1'b1;
    i_rd_addr = 4'd1;
    tick();
    i_rd_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_state", o_dbg_state, 0);
    check("rst_done_flag", o_done, 0);
    check("rst_done_wr_count", o_wr_count, 0);
    check("rst_done_trig_addr", o_trig_addr, 0);
    check("rst_done_rd_data", o_rd_data, 0);
    check("rst_done_rd_valid", o_rd_valid, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rd_inflight_dropped", valid_cnt - v0, 0);

    // Reset mid-ARM of a triggered capture that never triggers
    va = tbl[9];
    va.trig = 1000;
    i_mode         = 2'd2;
    i_sel_quadrant = 2'(va.sq);
    i_sel_if       = 3'(va.si);
    i_post_count   = 4'd2;
    drive_lines(va, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_lines(va, k);
      tick();
    end
    check("arm_busy", o_busy, 1);
    check("arm_state", o_dbg_state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_arm_busy", o_busy, 0);
    check("rst_arm_state", o_dbg_state, 0);
    check("rst_arm_wr_count", o_wr_count, 0);
    check("rst_arm_done", o_done, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_after_reset", o_busy, 0);
    check("idle_after_reset_state", o_dbg_state, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
